ram_master: RTL and testbench
=============================

# ram_master

Burst initiator for the 32x32 single-port synchronous RAM. Accepts read/write burst commands over a valid/ready handshake and drives the RAM's `cen`/`wen`/`S_addr`/`S_din` pins. It returns read data from `S_dout` through a credit-controlled output FIFO with backpressure. It sits between the datapath/control logic and the RAM instance in the top level.

## Interface
- `RD_FIFO_DEPTH`, 4: read-return FIFO entries; must be ≥ 2, and 4 gives full throughput.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when high with `cmd_valid`.
- `cmd_wr` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in 5: start word address.
- `cmd_len` in 5: burst length minus 1 (1..32 words).
- `cmd_err` out 1: one-cycle pulse, rejected command (see Configuration).
- `wr_valid` in 1, `wr_ready` out 1, `wr_data` in 32: write-data stream.
- `rd_valid` out 1, `rd_ready` in 1, `rd_data` out 32: read-data stream.
- `busy` out 1: high whenever not IDLE.
- `cen`, `wen` out 1: RAM chip enable and write enable, registered.
- `S_addr` out 5, `S_din` out 32: RAM address and write data, registered.
- `S_dout` in 32: RAM read data.

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`: latch addr, remaining=`cmd_len`, go to WRITE or READ.
- WRITE:
  - `wr_ready`=1.
  - Each `wr_valid&&wr_ready` beat registers `cen`=1, `wen`=1, `S_addr`=addr, `S_din`=`wr_data`.
  - Then addr+1, remaining-1.
  - After the beat with remaining==0, go to IDLE.
  - In cycles with no beat, `cen`=0.
- READ:
  - Issue (`cen`=1, `wen`=0, `S_addr`=addr) only when fifo_count + inflight < `RD_FIFO_DEPTH`.
  - After the last issue, go to DRAIN.
- DRAIN: wait until inflight==0, then go to IDLE. The FIFO may still hold data in IDLE.
- A 2-stage issue-flag shift register tracks inflight reads. `S_dout` is pushed to the FIFO only when the tagged flag emerges. `S_dout` is ignored at all other times, because the RAM outputs 0 on writes and on `cen`=0.
- Address arithmetic is 5-bit modulo: 31+1 → 0.
- FIFO pop on `rd_valid&&rd_ready`. Push and pop in the same cycle keeps the count.
- Reset value of every output is 0: `cen`, `wen`, `S_addr`, `S_din`, `rd_valid`, `rd_data`, `cmd_ready`, `wr_ready`, `cmd_err`, `busy`. After reset releases, the block is in IDLE with `cmd_ready`=1.
- Reset mid-burst: aborts the burst, flushes the FIFO and inflight flags, and drops pending read data.

## Timing
- Write: beat accepted at edge E → RAM pins valid during cycle E..E+1 → RAM writes at edge E+1. Throughput is 1 word/cycle.
- Read: issue at edge E → RAM samples at E+1 → FIFO push at E+2 → `rd_valid` high after E+2, i.e. 2-cycle latency.
- With `rd_ready` held high, throughput is 1 word/cycle.
- FIFO full: issue stalls; no read is lost.
- The next command is accepted the cycle after returning to IDLE. The minimum command gap is 1 cycle.
- `cmd_ready`, `wr_ready` and `busy` are decoded combinationally from state. `cen`/`wen`/`S_addr`/`S_din` are registered.

## Configuration
- `RAM_MASTER_NOWRAP_EN` defined:
  - A command with `cmd_addr`+`cmd_len` > 31 is accepted, `cmd_err` pulses 1 cycle, no RAM access occurs, and the FSM stays in IDLE.
- `RAM_MASTER_NOWRAP_EN` undefined:
  - Such bursts wrap 31→0.
  - `cmd_err` is tied 0.

## Structure
- Package `ram_pkg`: `ADDR_W`=5, `DATA_W`=32, `MEM_DEPTH`=32, FSM state encoding.
- Sub-module `ram_rd_fifo`: synchronous FIFO, `RD_FIFO_DEPTH` x 32.
  - Ports: push, pop, full, empty, count.
  - Reset clears it.
- `ram_master` instantiates `ram_rd_fifo`. The bench pairs it with the RAM model.

## Test plan
- Write burst addr=4, len=3, data 0xA0..0xA3 with `wr_valid` always high → 4 consecutive `cen`=`wen`=1 cycles at addr 4..7. A read of the same burst returns 0xA0..0xA3, first `rd_valid` 2 cycles after the first issue.
- Read burst addr=0, len=31 with `rd_ready` low for 10 cycles → issue stops at 4 outstanding words. After release, 32 words arrive in order with no loss or duplication.
- Write addr=30, len=3, data 1..4 → writes to addr 30, 31, 0, 1 (wrap). With `RAM_MASTER_NOWRAP_EN` defined: `cmd_err`=1 for 1 cycle, `cen` stays 0, `busy` stays 0.
- `wr_valid` toggled every other cycle during a 4-word write → `cen` pulses only on accepted beats and addresses increment per beat only.
- `reset` asserted during cycle 5 of a 16-word read → next cycle all outputs are 0, the FIFO is empty, and a following command at addr 0 behaves as from power-up.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared widths, FSM state encoding and address helpers for ram_master.
// Ports: none (package).
// Optional feature macro used by ram_master: RAM_MASTER_NOWRAP_EN.
package ram_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // True when a burst starting at addr with length-minus-one len would run
    // past the last RAM word.
    function automatic logic burst_overflows(input logic [ADDR_W-1:0] addr,
                                             input logic [ADDR_W-1:0] len);
        logic [ADDR_W:0] last;
        last = {1'b0, addr} + {1'b0, len};
        return last > (ADDR_W + 1)'(MEM_DEPTH - 1);
    endfunction

endpackage

// File: rtl/ram_master_if.sv
// ram_master_if: command, write-data and read-data streams of ram_master.
// Signals: cmd_valid/cmd_ready/cmd_wr/cmd_addr/cmd_len/cmd_err,
//          wr_valid/wr_ready/wr_data, rd_valid/rd_ready/rd_data, busy.
// Modports: master = upstream controller, slave = ram_master.
interface ram_master_if;
    import ram_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic              cmd_err;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy;

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
        input  cmd_ready, cmd_err, wr_ready, rd_valid, rd_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
        output cmd_ready, cmd_err, wr_ready, rd_valid, rd_data, busy
    );

endinterface

// File: rtl/ram_rd_fifo.sv
// ram_rd_fifo: show-ahead synchronous FIFO for RAM read returns.
// Ports: clk, reset (sync, active-high, clears pointers/count),
//        push/push_data, pop/pop_data, full, empty, count.
// pop_data reads 0 while empty so the read-data output is quiet after reset.
module ram_rd_fifo
    import ram_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_en, pop_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign pop_en  = pop && !empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign push_en = push && (!full || pop_en);
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_en  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries covered by count are ever visible.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ram_master.sv
// ram_master: burst initiator for the 32x32 single-port synchronous RAM.
// Ports: clk, reset (sync, active-high); bus (ram_master_if.slave: command,
//        write-data and read-data streams, cmd_err, busy);
//        cen/wen/S_addr/S_din registered RAM pins; S_dout RAM read data.
// Parameter: RD_FIFO_DEPTH (>= 2; 4 sustains one read word per cycle).
// Macro RAM_MASTER_NOWRAP_EN: reject bursts crossing address 31 with a
// one-cycle cmd_err pulse; otherwise bursts wrap 31 -> 0 and cmd_err is 0.
module ram_master
    import ram_pkg::*;
#(
    parameter int RD_FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    ram_master_if.slave       bus,
    output logic              cen,
    output logic              wen,
    output logic [ADDR_W-1:0] S_addr,
    output logic [DATA_W-1:0] S_din,
    input  logic [DATA_W-1:0] S_dout
);

    localparam int CNT_W = $clog2(RD_FIFO_DEPTH + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic              cen_q, cen_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_din_q, s_din_d;
    // flag_q[0]: read issued last edge; flag_q[1]: its data is on S_dout now.
    logic [1:0]        flag_q, flag_d;
    logic              issue;
    logic              reject;
    logic [1:0]        inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;
    logic              fifo_full, fifo_empty;

    assign inflight  = {1'b0, flag_q[0]} + {1'b0, flag_q[1]};
    // Reads already in the RAM pipeline are counted as if stored, so the FIFO
    // always has room for everything that will emerge.
    assign occupancy = {1'b0, fifo_count} + {{(CNT_W - 1){1'b0}}, inflight};

`ifdef RAM_MASTER_NOWRAP_EN
    logic cmd_err_q, cmd_err_d;
    assign reject      = burst_overflows(bus.cmd_addr, bus.cmd_len);
    assign bus.cmd_err = cmd_err_q;
`else
    assign reject      = 1'b0;
    assign bus.cmd_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        cen_d    = 1'b0;
        wen_d    = 1'b0;
        s_addr_d = s_addr_q;
        s_din_d  = s_din_q;
        issue    = 1'b0;
`ifdef RAM_MASTER_NOWRAP_EN
        cmd_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && !reject) begin
                    addr_d  = bus.cmd_addr;
                    rem_d   = bus.cmd_len;
                    state_d = bus.cmd_wr ? ST_WRITE : ST_READ;
                end
`ifdef RAM_MASTER_NOWRAP_EN
                cmd_err_d = bus.cmd_valid && reject;
`endif
            end
            ST_WRITE: begin
                if (bus.wr_valid) begin
                    cen_d    = 1'b1;
                    wen_d    = 1'b1;
                    s_addr_d = addr_q;
                    s_din_d  = bus.wr_data;
                    addr_d   = addr_q + ADDR_W'(1);
                    rem_d    = rem_q - ADDR_W'(1);
                    if (rem_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                if (occupancy < (CNT_W + 1)'(RD_FIFO_DEPTH) && !fifo_full) begin
                    issue    = 1'b1;
                    cen_d    = 1'b1;
                    s_addr_d = addr_q;
                    addr_d   = addr_q + ADDR_W'(1);
                    rem_d    = rem_q - ADDR_W'(1);
                    if (rem_q == '0) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (inflight == 2'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        flag_d = {flag_q[0], issue};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            cen_q    <= 1'b0;
            wen_q    <= 1'b0;
            s_addr_q <= '0;
            s_din_q  <= '0;
            flag_q   <= '0;
`ifdef RAM_MASTER_NOWRAP_EN
            cmd_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            cen_q    <= cen_d;
            wen_q    <= wen_d;
            s_addr_q <= s_addr_d;
            s_din_q  <= s_din_d;
            flag_q   <= flag_d;
`ifdef RAM_MASTER_NOWRAP_EN
            cmd_err_q <= cmd_err_d;
`endif
        end
    end

    ram_rd_fifo #(
        .DEPTH(RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (flag_q[1]),
        .push_data (S_dout),
        .pop       (bus.rd_ready),
        .pop_data  (bus.rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign cen    = cen_q;
    assign wen    = wen_q;
    assign S_addr = s_addr_q;
    assign S_din  = s_din_q;

    // cmd_ready is held low while reset is asserted so every output reads 0.
    assign bus.cmd_ready = (state_q == ST_IDLE) && !reset;
    assign bus.wr_ready  = (state_q == ST_WRITE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rd_valid  = !fifo_empty;

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: directed bench for ram_master paired with a 32x32 RAM model.
module tb_ram_master;
    import ram_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              ram_load;
    logic              cen, wen;
    logic [ADDR_W-1:0] S_addr;
    logic [DATA_W-1:0] S_din;
    logic [DATA_W-1:0] S_dout;
    logic [DATA_W-1:0] ram_mem [MEM_DEPTH];
    logic [DATA_W-1:0] shadow  [MEM_DEPTH];
    int                n_tests = 0;
    int                n_fail  = 0;

    ram_master_if bus ();

    ram_master #(
        .RD_FIFO_DEPTH(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .cen    (cen),
        .wen    (wen),
        .S_addr (S_addr),
        .S_din  (S_din),
        .S_dout (S_dout)
    );

    always #5 clk = ~clk;

    // RAM model: registered read, outputs 0 on writes and when disabled.
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < MEM_DEPTH; i++) ram_mem[i] <= 32'hC000_0000 + 32'(i);
            S_dout <= '0;
        end else if (cen) begin
            if (wen) begin
                ram_mem[S_addr] <= S_din;
                S_dout <= '0;
            end else begin
                S_dout <= ram_mem[S_addr];
            end
        end else begin
            S_dout <= '0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string p);
        check_eq({p, "_cen"},       32'(cen), 0);
        check_eq({p, "_wen"},       32'(wen), 0);
        check_eq({p, "_S_addr"},    32'(S_addr), 0);
        check_eq({p, "_S_din"},     S_din, 0);
        check_eq({p, "_rd_valid"},  32'(bus.rd_valid), 0);
        check_eq({p, "_rd_data"},   bus.rd_data, 0);
        check_eq({p, "_cmd_ready"}, 32'(bus.cmd_ready), 0);
        check_eq({p, "_wr_ready"},  32'(bus.wr_ready), 0);
        check_eq({p, "_cmd_err"},   32'(bus.cmd_err), 0);
        check_eq({p, "_busy"},      32'(bus.busy), 0);
    endtask

    task automatic write_burst(input logic [4:0] a, input logic [4:0] l,
                               input logic [31:0] d0, input bit toggle, input string nm);
        logic [4:0] ea;
        $display("[TB] write %s addr=%0d len=%0d", nm, a, l);
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        tick();
        bus.cmd_valid = 1'b0;
        check_eq({nm, "_busy"}, 32'(bus.busy), 1);
        for (int i = 0; i <= int'(l); i++) begin
            if (toggle) begin
                bus.wr_valid = 1'b0;
                tick();
                check_eq({nm, "_gap_cen"}, 32'(cen), 0);
                check_eq({nm, "_gap_wr_ready"}, 32'(bus.wr_ready), 1);
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = d0 + 32'(i);
            tick();
            ea = a + 5'(i);
            shadow[ea] = d0 + 32'(i);
            check_eq({nm, "_cen"},  32'(cen), 1);
            check_eq({nm, "_wen"},  32'(wen), 1);
            check_eq({nm, "_addr"}, 32'(S_addr), 32'(ea));
            check_eq({nm, "_din"},  S_din, d0 + 32'(i));
        end
        bus.wr_valid = 1'b0;
        check_eq({nm, "_idle_busy"}, 32'(bus.busy), 0);
        tick();
        check_eq({nm, "_end_cen"}, 32'(cen), 0);
    endtask

    task automatic read_burst(input logic [4:0] a, input logic [4:0] l,
                              input int stall, input string nm);
        int         issued, got, maxout, first_iss, first_rv, cyc, n;
        logic [4:0] ea;
        n = int'(l) + 1;
        $display("[TB] read %s addr=%0d len=%0d stall=%0d", nm, a, l, stall);
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.rd_ready  = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        check_eq({nm, "_busy"}, 32'(bus.busy), 1);
        issued = 0; got = 0; maxout = 0; first_iss = -1; first_rv = -1;
        for (cyc = 0; cyc < 300; cyc++) begin
            bus.rd_ready = (cyc >= stall);
            if (cen) begin
                ea = a + 5'(issued);
                check_eq({nm, "_iss_addr"}, 32'(S_addr), 32'(ea));
                check_eq({nm, "_iss_wen"}, 32'(wen), 0);
                if (first_iss < 0) first_iss = cyc;
                issued++;
            end
            if (issued - got > maxout) maxout = issued - got;
            if (bus.rd_valid && bus.rd_ready) begin
                if (got >= n) begin
                    check_eq({nm, "_extra_word"}, 1, 0);
                end else begin
                    ea = a + 5'(got);
                    check_eq({nm, "_data"}, bus.rd_data, shadow[ea]);
                end
                if (first_rv < 0) first_rv = cyc;
                got++;
            end
            if (got >= n && !bus.busy) break;
            tick();
        end
        tick();
        bus.rd_ready = 1'b0;
        check_eq({nm, "_timeout"}, 32'(cyc >= 300), 0);
        check_eq({nm, "_words"}, 32'(got), 32'(n));
        check_eq({nm, "_issues"}, 32'(issued), 32'(n));
        check_eq({nm, "_fifo_empty"}, 32'(bus.rd_valid), 0);
        if (stall == 0) check_eq({nm, "_latency"}, 32'(first_rv - first_iss), 2);
        else            check_eq({nm, "_max_outstanding"}, 32'(maxout), 4);
    endtask

    initial begin
        reset         = 1'b1;
        ram_load      = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;
        for (int i = 0; i < MEM_DEPTH; i++) shadow[i] = 32'hC000_0000 + 32'(i);

        repeat (3) tick();
        ram_load = 1'b0;
        $display("[TB] power-up reset");
        check_outputs_zero("por");
        reset = 1'b0;
        #1;
        check_eq("por_cmd_ready", 32'(bus.cmd_ready), 1);
        check_eq("por_busy", 32'(bus.busy), 0);

        write_burst(5'd4, 5'd3, 32'h0000_00A0, 1'b0, "wr4");
        read_burst(5'd4, 5'd3, 0, "rd4");
        read_burst(5'd0, 5'd31, 10, "rd32");

`ifdef RAM_MASTER_NOWRAP_EN
        $display("[TB] write wrap addr=30 len=3 (expect reject)");
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = 1'b1;
        bus.cmd_addr  = 5'd30;
        bus.cmd_len   = 5'd3;
        tick();
        bus.cmd_valid = 1'b0;
        check_eq("nowrap_err", 32'(bus.cmd_err), 1);
        check_eq("nowrap_busy", 32'(bus.busy), 0);
        check_eq("nowrap_cen", 32'(cen), 0);
        tick();
        check_eq("nowrap_err_clear", 32'(bus.cmd_err), 0);
        check_eq("nowrap_cen2", 32'(cen), 0);
        check_eq("nowrap_busy2", 32'(bus.busy), 0);
`else
        write_burst(5'd30, 5'd3, 32'd1, 1'b0, "wrap");
        check_eq("wrap_err", 32'(bus.cmd_err), 0);
        read_burst(5'd30, 5'd3, 0, "rdwrap");
`endif

        write_burst(5'd10, 5'd3, 32'h0000_0050, 1'b1, "tog");
        read_burst(5'd10, 5'd3, 0, "rdtog");

        $display("[TB] read addr=0 len=15 with reset in cycle 5");
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = 5'd0;
        bus.cmd_len   = 5'd15;
        bus.rd_ready  = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        repeat (4) tick();
        check_eq("mid_rd_valid_before", 32'(bus.rd_valid), 1);
        reset = 1'b1;
        tick();
        check_outputs_zero("mid");
        reset = 1'b0;
        #1;
        check_eq("mid_cmd_ready", 32'(bus.cmd_ready), 1);
        check_eq("mid_rd_valid_after", 32'(bus.rd_valid), 0);
        read_burst(5'd0, 5'd3, 0, "post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
